// File: rtl/player_action_input_pkg.sv
// Shared types and keycode constants for the poker player-input path.
// The HOLD_REPEAT_EN macro enables arrow-key auto-repeat in key_press_detect.
package player_action_input_pkg;

    typedef enum logic [1:0] {
        FOLD       = 2'd0,
        CHECK_CALL = 2'd1,
        BET_RAISE  = 2'd2,
        ALL_IN     = 2'd3
    } action_t;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_B     = 8'h05;
    localparam logic [7:0] KEY_C     = 8'h06;
    localparam logic [7:0] KEY_F     = 8'h09;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_ESC   = 8'h29;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_UP    = 8'h52;

    function automatic logic [10:0] min_chips(input logic [10:0] a, input logic [10:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/player_action_input_key_press_detect.sv
// Turns a level-held keycode into a one-cycle press pulse.
// With HOLD_REPEAT_EN defined, a held key (while repeat_en) also fires repeat pulses.
module key_press_detect #(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       repeat_en,
    output logic       press
);
    import player_action_input_pkg::*;

    logic [7:0] prev_key;
    logic       strobe;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) prev_key <= KEY_NONE;
        else       prev_key <= keycode;
    end

    assign strobe = (keycode != KEY_NONE) && (keycode != prev_key);

`ifdef HOLD_REPEAT_EN
    localparam int CW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    localparam logic [CW-1:0] FIRST_AT = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] NEXT_AT  = CW'(REPEAT_DELAY + REPEAT_PERIOD);
    localparam logic [CW-1:0] RELOAD   = CW'(REPEAT_DELAY + 1);

    // hold_cnt equals the number of cycles since the press edge; it loops between RELOAD and NEXT_AT.
    logic [CW-1:0] hold_cnt;
    logic          repeat_fire;

    assign repeat_fire = repeat_en && (keycode == prev_key)
                         && ((hold_cnt == FIRST_AT) || (hold_cnt == NEXT_AT));

    always_ff @(posedge Clk) begin
        if (Reset || !repeat_en)         hold_cnt <= '0;
        else if (keycode != prev_key)    hold_cnt <= CW'(1);
        else if (hold_cnt == NEXT_AT)    hold_cnt <= RELOAD;
        else                             hold_cnt <= hold_cnt + CW'(1);
    end

    assign press = strobe | repeat_fire;
`else
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
    logic unused_repeat_en;
    assign unused_repeat_en = repeat_en;
    assign press = strobe;
`endif

endmodule

// File: rtl/player_action_input.sv
// Keyboard-driven action selector: one validated action per turn for the poker FSM.
// Optional arrow auto-repeat is enabled by defining HOLD_REPEAT_EN.
module player_action_input
    import player_action_input_pkg::*;
#(
    parameter int BET_STEP      = 10,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [7:0]       keycode,
    input  logic             turn_active,
    input  logic             current_player,
    input  logic [1:0][10:0] player_stacks,
    input  logic [10:0]      min_bet_or_raise,
    input  logic [10:0]      call_size,
    input  logic             if_BetCheck,
    input  logic             action_ready,
    output logic             action_valid,
    output action_t          action_type,
    output logic [10:0]      action_amount,
    output logic [10:0]      bet_amount,
    output logic             editing
);

    typedef enum logic [1:0] {WAIT_TURN, SELECT, ADJUST, ISSUE} action_state_t;

    localparam logic [11:0] STEP_W = 12'(BET_STEP);

    action_state_t state, next_state;
    logic          turn_armed;
    logic          press;
    logic          repeat_en;
    logic [10:0]   stack, floor_amt, bet_up, bet_down;
    logic [11:0]   up_sum;

    assign stack     = player_stacks[current_player];
    assign floor_amt = min_chips(min_bet_or_raise, stack);
    assign repeat_en = (state == ADJUST) && ((keycode == KEY_UP) || (keycode == KEY_DOWN));

    // Arithmetic is one bit wider so the step can neither overflow upward nor wrap below the floor.
    assign up_sum   = {1'b0, bet_amount} + STEP_W;
    assign bet_up   = (up_sum > {1'b0, stack}) ? stack : up_sum[10:0];
    assign bet_down = ({1'b0, bet_amount} >= ({1'b0, floor_amt} + STEP_W))
                      ? (bet_amount - STEP_W[10:0]) : floor_amt;

    key_press_detect #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_key (
        .Clk      (Clk),
        .Reset    (Reset),
        .keycode  (keycode),
        .repeat_en(repeat_en),
        .press    (press)
    );

    always_ff @(posedge Clk) begin
        if (Reset) state <= WAIT_TURN;
        else       state <= next_state;
    end

    // NOTE: next_state gets a default first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            WAIT_TURN: if (turn_active && turn_armed) next_state = SELECT;
            SELECT: begin
                if (!turn_active) next_state = WAIT_TURN;
                else if (press) begin
                    case (keycode)
                        KEY_F, KEY_C, KEY_A: next_state = ISSUE;
                        KEY_B:               next_state = ADJUST;
                        default:             next_state = SELECT;
                    endcase
                end
            end
            ADJUST: begin
                if (!turn_active) next_state = WAIT_TURN;
                else if (press && keycode == KEY_ENTER) next_state = ISSUE;
                else if (press && keycode == KEY_ESC)   next_state = SELECT;
            end
            ISSUE: if (action_ready) next_state = WAIT_TURN;
            default: next_state = WAIT_TURN;
        endcase
    end

    always_comb begin
        action_valid = 1'b0;
        editing      = 1'b0;
        case (state)
            ISSUE:   action_valid = 1'b1;
            ADJUST:  editing      = 1'b1;
            default: ;
        endcase
    end

    // A turn is re-armed only after turn_active is seen low, so one assertion yields one action.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bet_amount    <= '0;
            action_type   <= FOLD;
            action_amount <= '0;
            turn_armed    <= 1'b1;
        end else begin
            if (state == ISSUE && action_ready) turn_armed <= 1'b0;
            else if (!turn_active)              turn_armed <= 1'b1;

            case (state)
                WAIT_TURN: if (turn_active && turn_armed) bet_amount <= floor_amt;
                SELECT: if (turn_active && press) begin
                    case (keycode)
                        KEY_F: begin
                            action_type   <= FOLD;
                            action_amount <= '0;
                        end
                        KEY_C: begin
                            action_type   <= CHECK_CALL;
                            action_amount <= if_BetCheck ? 11'd0 : min_chips(call_size, stack);
                        end
                        KEY_A: begin
                            action_type   <= ALL_IN;
                            action_amount <= stack;
                        end
                        default: ;
                    endcase
                end
                ADJUST: if (turn_active && press) begin
                    case (keycode)
                        KEY_UP:   bet_amount <= bet_up;
                        KEY_DOWN: bet_amount <= bet_down;
                        KEY_ESC:  bet_amount <= floor_amt;
                        KEY_ENTER: begin
                            action_type   <= (bet_amount == stack) ? ALL_IN : BET_RAISE;
                            action_amount <= bet_amount;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_player_action_input.sv
// Directed self-checking bench for player_action_input (default build and HOLD_REPEAT_EN build).
module tb_player_action_input;
    import player_action_input_pkg::*;

    logic             Clk = 1'b0;
    logic             Reset;
    logic [7:0]       keycode;
    logic             turn_active;
    logic             current_player;
    logic [1:0][10:0] player_stacks;
    logic [10:0]      min_bet_or_raise;
    logic [10:0]      call_size;
    logic             if_BetCheck;
    logic             action_ready;
    logic             action_valid;
    action_t          action_type;
    logic [10:0]      action_amount;
    logic [10:0]      bet_amount;
    logic             editing;

    int checks   = 0;
    int failures = 0;

    player_action_input #(
        .BET_STEP     (10),
        .REPEAT_DELAY (8),
        .REPEAT_PERIOD(4)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .keycode         (keycode),
        .turn_active     (turn_active),
        .current_player  (current_player),
        .player_stacks   (player_stacks),
        .min_bet_or_raise(min_bet_or_raise),
        .call_size       (call_size),
        .if_BetCheck     (if_BetCheck),
        .action_ready    (action_ready),
        .action_valid    (action_valid),
        .action_type     (action_type),
        .action_amount   (action_amount),
        .bet_amount      (bet_amount),
        .editing         (editing)
    );

    always #5 Clk = ~Clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic press(input logic [7:0] k);
        keycode = k;
        step();
        keycode = KEY_NONE;
        step();
    endtask

    task automatic start_turn();
        turn_active = 1'b0;
        step();
        turn_active = 1'b1;
        step();
    endtask

    task automatic expect_action(input string name, input action_t t, input logic [10:0] amt);
        checks++;
        if (action_valid !== 1'b1 || action_type !== t || action_amount !== amt) begin
            failures++;
            $display("FAIL %s: got valid=%0b type=%0d amount=%0d, want valid=1 type=%0d amount=%0d",
                     name, action_valid, int'(action_type), action_amount, int'(t), amt);
        end
    endtask

    task automatic expect_bet(input string name, input logic [10:0] exp);
        checks++;
        if (bet_amount !== exp) begin
            failures++;
            $display("FAIL %s: bet_amount got %0d want %0d", name, bet_amount, exp);
        end
    endtask

    task automatic complete_handshake(input string name);
        action_ready = 1'b1;
        step();
        action_ready = 1'b0;
        checks++;
        if (action_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s: action_valid got %0b want 0 after handshake", name, action_valid);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; keycode = KEY_NONE; turn_active = 1'b0; current_player = 1'b0;
        player_stacks = '0; min_bet_or_raise = '0; call_size = '0; if_BetCheck = 1'b0; action_ready = 1'b0;
        step(); step();
        checks++;
        if (action_valid !== 1'b0 || editing !== 1'b0 || action_type !== FOLD
            || action_amount !== 11'd0 || bet_amount !== 11'd0) begin
            failures++;
            $display("FAIL reset: valid=%0b editing=%0b type=%0d amount=%0d bet=%0d, want all zero/FOLD",
                     action_valid, editing, int'(action_type), action_amount, bet_amount);
        end
        Reset = 1'b0;
    endtask

    task automatic test_check_call();
        player_stacks[0] = 11'd500; player_stacks[1] = 11'd45; current_player = 1'b0;
        min_bet_or_raise = 11'd20; call_size = 11'd40; if_BetCheck = 1'b0;
        turn_active = 1'b1;
        step();
        expect_bet("turn_load", 11'd20);
        keycode = KEY_C;
        step();
        expect_action("call_latency", CHECK_CALL, 11'd40);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_action("call_stable", CHECK_CALL, 11'd40);
        end
        complete_handshake("call_drop");
        keycode = KEY_NONE;
        step();
        press(KEY_C);
        checks++;
        if (action_valid !== 1'b0) begin
            failures++;
            $display("FAIL no_rearm: action_valid got %0b want 0", action_valid);
        end
        if_BetCheck = 1'b1;
        start_turn();
        press(KEY_C);
        expect_action("check_zero", CHECK_CALL, 11'd0);
        complete_handshake("check_drop");
        if_BetCheck = 1'b0;
    endtask

    task automatic test_bet_adjust();
        logic [10:0] exp_up [4];
        exp_up = '{11'd30, 11'd40, 11'd45, 11'd45};
        current_player = 1'b1;
        start_turn();
        expect_bet("adj_start", 11'd20);
        press(KEY_B);
        checks++;
        if (editing !== 1'b1) begin
            failures++;
            $display("FAIL adj_editing: editing got %0b want 1", editing);
        end
        for (int i = 0; i < 4; i++) begin
            press(KEY_UP);
            expect_bet("adj_up", exp_up[i]);
        end
        press(KEY_ENTER);
        expect_action("adj_allin", ALL_IN, 11'd45);
        complete_handshake("adj_allin_drop");
        start_turn();
        press(KEY_B);
        press(KEY_UP);
        press(KEY_ENTER);
        expect_action("adj_raise", BET_RAISE, 11'd30);
        complete_handshake("adj_raise_drop");
        current_player = 1'b0;
    endtask

    task automatic test_adjust_escape();
        start_turn();
        press(KEY_B);
        for (int i = 0; i < 2; i++) begin
            press(KEY_DOWN);
            expect_bet("esc_down_floor", 11'd20);
        end
        press(KEY_ESC);
        checks++;
        if (editing !== 1'b0 || bet_amount !== 11'd20) begin
            failures++;
            $display("FAIL esc_return: editing=%0b bet=%0d want editing=0 bet=20", editing, bet_amount);
        end
        press(KEY_F);
        expect_action("esc_fold", FOLD, 11'd0);
        complete_handshake("esc_fold_drop");
    endtask

    task automatic test_ignore_and_abort();
        start_turn();
        press(KEY_UP);
        checks++;
        if (action_valid !== 1'b0 || editing !== 1'b0 || bet_amount !== 11'd20) begin
            failures++;
            $display("FAIL select_ignore: valid=%0b editing=%0b bet=%0d want 0/0/20",
                     action_valid, editing, bet_amount);
        end
        press(KEY_B);
        press(KEY_UP);
        expect_bet("abort_up", 11'd30);
        turn_active = 1'b0;
        step();
        checks++;
        if (editing !== 1'b0) begin
            failures++;
            $display("FAIL abort_editing: editing got %0b want 0", editing);
        end
        turn_active = 1'b1;
        step();
        expect_bet("abort_reload", 11'd20);
        press(KEY_A);
        expect_action("abort_allin", ALL_IN, 11'd500);
        complete_handshake("abort_allin_drop");
    endtask

    task automatic test_hold_key();
        int valid_cycles;
        valid_cycles = 0;
        start_turn();
        action_ready = 1'b1;
        keycode = KEY_C;
        for (int i = 0; i < 100; i++) begin
            step();
            if (action_valid === 1'b1) valid_cycles++;
        end
        keycode = KEY_NONE;
        step();
        keycode = KEY_C;
        for (int i = 0; i < 5; i++) begin
            step();
            if (action_valid === 1'b1) valid_cycles++;
        end
        keycode = KEY_NONE;
        action_ready = 1'b0;
        step();
        checks++;
        if (valid_cycles !== 1) begin
            failures++;
            $display("FAIL hold_single: valid cycles got %0d want 1", valid_cycles);
        end
    endtask

    task automatic test_reset_mid_handshake();
        start_turn();
        press(KEY_A);
        expect_action("rst_pre", ALL_IN, 11'd500);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checks++;
        if (action_valid !== 1'b0 || bet_amount !== 11'd0 || editing !== 1'b0
            || action_type !== FOLD || action_amount !== 11'd0) begin
            failures++;
            $display("FAIL rst_mid: valid=%0b bet=%0d editing=%0b type=%0d amount=%0d want 0/0/0/FOLD/0",
                     action_valid, bet_amount, editing, int'(action_type), action_amount);
        end
        step();
        checks++;
        if (action_valid !== 1'b0 || bet_amount !== 11'd20) begin
            failures++;
            $display("FAIL rst_recover: valid=%0b bet=%0d want 0/20", action_valid, bet_amount);
        end
        turn_active = 1'b0;
        step();
    endtask

    task automatic test_zero_stack();
        player_stacks[0] = 11'd0;
        start_turn();
        expect_bet("zero_load", 11'd0);
        press(KEY_C);
        expect_action("zero_call", CHECK_CALL, 11'd0);
        complete_handshake("zero_call_drop");
        start_turn();
        press(KEY_B);
        press(KEY_UP);
        expect_bet("zero_up", 11'd0);
        press(KEY_DOWN);
        expect_bet("zero_down", 11'd0);
        press(KEY_ENTER);
        expect_action("zero_enter", ALL_IN, 11'd0);
        complete_handshake("zero_enter_drop");
    endtask

    task automatic test_hold_repeat();
        logic [10:0] exp;
        player_stacks[0] = 11'd55;
        start_turn();
        press(KEY_B);
        keycode = KEY_UP;
        step();
        expect_bet("repeat_press", 11'd30);
        for (int i = 1; i <= 20; i++) begin
            step();
`ifdef HOLD_REPEAT_EN
            exp = (i < 8) ? 11'd30 : (i < 12) ? 11'd40 : (i < 16) ? 11'd50 : 11'd55;
`else
            exp = 11'd30;
`endif
            checks++;
            if (bet_amount !== exp) begin
                failures++;
                $display("FAIL repeat_hold cycle %0d: bet_amount got %0d want %0d", i, bet_amount, exp);
            end
        end
        keycode = KEY_NONE;
        step();
        press(KEY_ESC);
        turn_active = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_check_call();
        test_bet_adjust();
        test_adjust_escape();
        test_ignore_and_abort();
        test_hold_key();
        test_reset_mid_handshake();
        test_zero_stack();
        test_hold_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
